// File: rtl/color_pkg.sv
// Shared constants, FSM state encoding and accumulator record for the
// colour-zone bounding-box detector.
package color_pkg;

  localparam int DEF_IMG_W     = 640;
  localparam int DEF_IMG_H     = 480;
  localparam int DEF_MIN_RUN   = 4;
  localparam int DEF_MIN_COUNT = 64;

  localparam int XW = 10;
  localparam int YW = 10;
  localparam int CW = 20;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    FRAME   = 2'd1,
    BLANK   = 2'd2
  } frame_state_t;

  typedef struct packed {
    logic [XW-1:0] x_min;
    logic [XW-1:0] x_max;
    logic [YW-1:0] y_min;
    logic [YW-1:0] y_max;
    logic [CW-1:0] pix_cnt;
  } bbox_t;

  // Pixel-count addition that pins at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    logic [CW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
  endfunction

endpackage

// File: rtl/color_bbox_detect_run_filter.sv
// Horizontal run-length filter: a mask pixel only qualifies once it sits in a
// run of at least MIN_RUN consecutive ones on the same line.
module mask_run_filter #(
  parameter int MIN_RUN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mask_bit,
  input  logic strobe,
  input  logic line_clr,
  output logic qual_first,
  output logic qual_cont
);

  localparam int RW = $clog2(MIN_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MIN_RUN);
  localparam logic [RW-1:0] RUN_PRE = RW'(MIN_RUN - 1);

  logic [RW-1:0] run;

  // Decisions use the run length before this pixel, so they line up with the
  // pixel's own x/y in the top level.
  assign qual_first = strobe & mask_bit & (run == RUN_PRE);
  assign qual_cont  = strobe & mask_bit & (run == RUN_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run <= '0;
    end else if (line_clr) begin
      run <= '0;
    end else if (strobe) begin
      if (!mask_bit)
        run <= '0;
      else if (run != RUN_MAX)
        run <= run + RW'(1);
    end
  end

endmodule

// File: rtl/color_bbox_detect.sv
// Frame-level bounding-box accumulator: tracks x/y, collects the extent and
// count of run-qualified mask pixels, and publishes them once per frame.
module color_bbox_detect
  import color_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int MIN_RUN   = DEF_MIN_RUN,
  parameter int MIN_COUNT = DEF_MIN_COUNT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic          per_img_bit,
  output logic [XW-1:0] box_x_min,
  output logic [XW-1:0] box_x_max,
  output logic [YW-1:0] box_y_min,
  output logic [YW-1:0] box_y_max,
  output logic [CW-1:0] box_pix_cnt,
  output logic          box_found,
  output logic          box_valid
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  frame_state_t  state;
  logic          vs_d;
  logic          href_d;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_full;
  logic          y_full;
  bbox_t         acc;

  logic          vs_rise;
  logic          vs_fall;
  logic          in_frame;
  logic          href_fall;
  logic          pix_valid;
  logic          line_clr;
  logic          qual_first;
  logic          qual_cont;
  logic          qualify;
  logic [CW-1:0] cnt_inc;
  logic [XW-1:0] x_left;

  assign vs_rise   = per_frame_vsync & ~vs_d;
  assign vs_fall   = ~per_frame_vsync & vs_d;
  assign in_frame  = (state == FRAME);
  assign href_fall = in_frame & href_d & ~per_frame_href;
  // x_full / y_full drop strobes past the right edge and lines past the bottom.
  assign pix_valid = in_frame & ~per_frame_vsync & per_frame_href &
                     per_frame_clken & ~x_full & ~y_full;
  assign line_clr  = href_fall | vs_fall;
  assign qualify   = qual_first | qual_cont;

  mask_run_filter #(
    .MIN_RUN (MIN_RUN)
  ) u_run_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .mask_bit   (per_img_bit),
    .strobe     (pix_valid),
    .line_clr   (line_clr),
    .qual_first (qual_first),
    .qual_cont  (qual_cont)
  );

  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned (no latch).
    cnt_inc = CW'(1);
    x_left  = x;
    if (qual_first) begin
      // The whole run becomes valid at once, so credit it back to its start.
      cnt_inc = CW'(MIN_RUN);
      x_left  = x - XW'(MIN_RUN - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WAIT_VS;
      vs_d        <= 1'b0;
      href_d      <= 1'b0;
      x           <= '0;
      y           <= '0;
      x_full      <= 1'b0;
      y_full      <= 1'b0;
      acc         <= '0;
      box_x_min   <= '0;
      box_x_max   <= '0;
      box_y_min   <= '0;
      box_y_max   <= '0;
      box_pix_cnt <= '0;
      box_found   <= 1'b0;
      box_valid   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every term reads pre-edge values.
      vs_d      <= per_frame_vsync;
      href_d    <= per_frame_href;
      box_valid <= 1'b0;

      case (state)
        WAIT_VS: if (vs_fall) state <= FRAME;
        FRAME: begin
          if (vs_rise) begin
            state       <= BLANK;
            box_valid   <= 1'b1;
            box_pix_cnt <= acc.pix_cnt;
            if (acc.pix_cnt >= CW'(MIN_COUNT)) begin
              box_found <= 1'b1;
              box_x_min <= acc.x_min;
              box_x_max <= acc.x_max;
              box_y_min <= acc.y_min;
              box_y_max <= acc.y_max;
            end else begin
              box_found <= 1'b0;
              box_x_min <= '0;
              box_x_max <= '0;
              box_y_min <= '0;
              box_y_max <= '0;
            end
          end
        end
        BLANK:   if (vs_fall) state <= FRAME;
        default: state <= WAIT_VS;
      endcase

      if (vs_fall) begin
        x           <= '0;
        y           <= '0;
        x_full      <= 1'b0;
        y_full      <= 1'b0;
        acc.x_min   <= X_LAST;
        acc.x_max   <= '0;
        acc.y_min   <= Y_LAST;
        acc.y_max   <= '0;
        acc.pix_cnt <= '0;
      end else begin
        if (href_fall) begin
          x      <= '0;
          x_full <= 1'b0;
          if (y == Y_LAST)
            y_full <= 1'b1;
          else
            y <= y + YW'(1);
        end

        if (pix_valid) begin
          if (x == X_LAST)
            x_full <= 1'b1;
          else
            x <= x + XW'(1);

          if (qualify) begin
            acc.pix_cnt <= sat_add(acc.pix_cnt, cnt_inc);
            if (x_left < acc.x_min) acc.x_min <= x_left;
            if (x > acc.x_max)      acc.x_max <= x;
            if (y < acc.y_min)      acc.y_min <= y;
            if (y > acc.y_max)      acc.y_max <= y;
          end
        end
      end
    end
  end

endmodule
